resv_station_pipn: RTL and testbench
====================================

// Module: resv_station_pipn
// PURPOSE
//  Parametrised N-entry collapsing reservation station; next generation of the per-cell RS, owning the whole entry array.
//  Accepts one decoded uop per cycle and snoops N_WB writeback channels for operand wakeup.
//  Issues up to one oldest-ready uop per pipe to N_PIP execute pipes. Sits between decoder/rename and the ALU pipes.
// PARAMETERS
//  DEPTH    8   entries; slot 0 always oldest
//  N_PIP    2   issue pipes; PIPW = $clog2(N_PIP) (min 1)
//  N_WB     2   writeback/wakeup channels
//  W_UOPS   6   uop code width
//  W_RX_A   5   register address width; address 0 never woken (hard zero)
//  W_RX_D   32  register data width
//  W_IMM_D  32  immediate width
//  W_PC_D   32  pc width
// PORTS
//  clk        in   1                 clock, rising edge
//  clear_n    in   1                 async active-low reset
//  flush      in   1                 sync: drop all entries
//  in_valid   in   1                 dispatch request
//  in_ready   out  1                 = (count < DEPTH)
//  in_pip     in   PIPW              target pipe
//  in_uops    in   W_UOPS            uop code
//  in_rd_a    in   W_RX_A            destination address
//  in_rs_v/in_rt_v in 1              operand valid
//  in_rs_a/in_rt_a in W_RX_A         operand source address
//  in_rs_d/in_rt_d in W_RX_D         operand data (used when valid)
//  in_imm_d   in   W_IMM_D           immediate
//  in_pc_d    in   W_PC_D            pc
//  wb_valid   in   N_WB              wakeup strobe per channel
//  wb_a       in   N_WB*W_RX_A       wakeup address, ch k at [k*W_RX_A +: W_RX_A]
//  wb_d       in   N_WB*W_RX_D       wakeup data, packed likewise
//  iss_valid  out  N_PIP             pipe p has a ready entry
//  iss_ready  in   N_PIP             pipe p accepts this cycle
//  iss_uops/rd_a/rs_d/rt_d/imm_d/pc_d out N_PIP*width  packed per pipe
//  count      out  $clog2(DEPTH+1)   occupied entries
// BEHAVIOUR
//  - Reset: all entries invalid, count=0, iss_valid=0, in_ready=1; outputs settle with no clock.
//  - Entry ready = valid & rs_v & rt_v. Select: per pipe p, lowest-index ready entry with pip==p drives iss_*[p] combinationally (0-cycle).
//  - Issue fires on iss_valid[p]&iss_ready[p]; entry removed at next edge. iss_* data = 0 when iss_valid[p]=0.
//  - Collapse: each edge, survivors shift toward slot 0 keeping age order; gaps from up to N_PIP removals closed same edge.
//  - Insert on in_valid&in_ready at slot (count - issued_this_cycle). Insert+issue same cycle legal; count += ins - issued.
//  - in_ready ignores same-cycle issue (full stays full one cycle).
//  - Wakeup: any stored/shifting entry with !rs_v and rs_a==wb_a[k], wb_valid[k], wb_a[k]!=0 sets rs_v=1, rs_d=wb_d[k]; rt identical.
//    Several channels match: lowest k wins. Wakeup of an entry also selected that cycle has no effect on its issue.
//  - Woken entry issuable the cycle after wakeup (no same-cycle wakeup-to-issue).
//  - flush: highest priority; all entries invalid next edge, insert that cycle dropped, count=0.
//  - Reset asserted mid-operation: immediate return to reset state; in-flight handshakes lost.
// CONFIGURATION
//  RS_WB_BYPASS_EN defined: inserting uop snoops wb_* same cycle; matching invalid operand stored valid with wb data.
//  Not defined: insert stores in_* as given; decoder operand read forwards same-cycle writebacks itself.
// STRUCTURE
//  Package resv_pkg: W_* defaults, entry struct/field offsets, unused_op constant, wakeup match function.
//  Sub-module resv_entry_wake: one entry's operand wakeup match/merge (N_WB compare), instantiated per entry and per insert port.
//  Top holds entry array, collapse mux, per-pipe priority select, counter.
// TESTING
//  T1 reset: clear_n=0 mid-traffic -> count=0, iss_valid=0, in_ready=1 with no clock edge.
//  T2 fill: 8 inserts, none ready -> count=8, in_ready=0; insert held; wb r3 wakes slot 5 -> iss_valid[pip] next cycle.
//  T3 age order: slots 1,4 both ready for pipe0 -> slot 1 issues first; after issue slots collapse, old slot 4 now slot 3.
//  T4 dual issue+insert: count=5, pipe0 and pipe1 issue, insert -> count=4, new entry at slot 3.
//  T5 wakeup clash: wb_a[0]=wb_a[1]=7, data 0xA/0xB -> entry rs_d=0xA; wb_a=0 with valid -> no entry woken.
//  T6 flush+insert same cycle -> count=0; with RS_WB_BYPASS_EN, insert rs_a=9 with wb r9 -> issues next cycle.

Source files
------------

// File: rtl/resv_pkg.sv
// Shared defaults and helpers for the collapsing reservation station.
package resv_pkg;

    localparam int RS_DEPTH   = 8;
    localparam int RS_N_PIP   = 2;
    localparam int RS_N_WB    = 2;
    localparam int RS_W_UOPS  = 6;
    localparam int RS_W_RX_A  = 5;
    localparam int RS_W_RX_D  = 32;
    localparam int RS_W_IMM_D = 32;
    localparam int RS_W_PC_D  = 32;

    // Register addresses are zero-extended to this width before comparison.
    localparam int RS_A_MAX = 16;

    // Value presented on iss_uops while a pipe has nothing to issue.
    localparam logic [RS_W_UOPS-1:0] UNUSED_OP = 6'd0;

    // Wakeup match: live strobe, operand still waiting, same register, register 0 is never written.
    function automatic logic wake_hit(
        input logic                wb_v,
        input logic                op_v,
        input logic [RS_A_MAX-1:0] wb_a,
        input logic [RS_A_MAX-1:0] op_a
    );
        return wb_v & ~op_v & (wb_a == op_a) & (wb_a != {RS_A_MAX{1'b0}});
    endfunction

endpackage

// File: rtl/resv_entry_wake.sv
// Operand wakeup merge for one entry: snoops all writeback channels, lowest channel wins.
module resv_entry_wake
    import resv_pkg::*;
#(
    parameter int N_WB   = RS_N_WB,
    parameter int W_RX_A = RS_W_RX_A,
    parameter int W_RX_D = RS_W_RX_D
) (
    input  logic                   rs_v_i,
    input  logic [W_RX_A-1:0]      rs_a_i,
    input  logic [W_RX_D-1:0]      rs_d_i,
    input  logic                   rt_v_i,
    input  logic [W_RX_A-1:0]      rt_a_i,
    input  logic [W_RX_D-1:0]      rt_d_i,
    input  logic [N_WB-1:0]        wb_valid_i,
    input  logic [N_WB*W_RX_A-1:0] wb_a_i,
    input  logic [N_WB*W_RX_D-1:0] wb_d_i,
    output logic                   rs_v_o,
    output logic [W_RX_D-1:0]      rs_d_o,
    output logic                   rt_v_o,
    output logic [W_RX_D-1:0]      rt_d_o
);

    logic [N_WB-1:0] rs_hit_s;
    logic [N_WB-1:0] rt_hit_s;

    // Descending scan so the lowest matching channel is the last one written.
    always_comb begin
        rs_v_o = rs_v_i;
        rs_d_o = rs_d_i;
        rt_v_o = rt_v_i;
        rt_d_o = rt_d_i;
        for (int k = N_WB - 1; k >= 0; k--) begin
            rs_hit_s[k] = wake_hit(wb_valid_i[k], rs_v_i,
                                   RS_A_MAX'(wb_a_i[k*W_RX_A +: W_RX_A]), RS_A_MAX'(rs_a_i));
            rt_hit_s[k] = wake_hit(wb_valid_i[k], rt_v_i,
                                   RS_A_MAX'(wb_a_i[k*W_RX_A +: W_RX_A]), RS_A_MAX'(rt_a_i));
            rs_v_o = rs_v_o | rs_hit_s[k];
            rs_d_o = rs_hit_s[k] ? wb_d_i[k*W_RX_D +: W_RX_D] : rs_d_o;
            rt_v_o = rt_v_o | rt_hit_s[k];
            rt_d_o = rt_hit_s[k] ? wb_d_i[k*W_RX_D +: W_RX_D] : rt_d_o;
        end
    end

endmodule

// File: rtl/resv_station_pipn.sv
// Collapsing reservation station: slot 0 oldest, per-pipe oldest-ready issue, writeback wakeup.
// Optional feature macro RS_WB_BYPASS_EN: dispatched operands also snoop same-cycle writebacks.
module resv_station_pipn
    import resv_pkg::*;
#(
    parameter int DEPTH   = RS_DEPTH,
    parameter int N_PIP   = RS_N_PIP,
    parameter int N_WB    = RS_N_WB,
    parameter int W_UOPS  = RS_W_UOPS,
    parameter int W_RX_A  = RS_W_RX_A,
    parameter int W_RX_D  = RS_W_RX_D,
    parameter int W_IMM_D = RS_W_IMM_D,
    parameter int W_PC_D  = RS_W_PC_D,
    localparam int PIPW   = (N_PIP > 1) ? $clog2(N_PIP) : 1,
    localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     clear_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PIPW-1:0]          in_pip,
    input  logic [W_UOPS-1:0]        in_uops,
    input  logic [W_RX_A-1:0]        in_rd_a,
    input  logic                     in_rs_v,
    input  logic [W_RX_A-1:0]        in_rs_a,
    input  logic [W_RX_D-1:0]        in_rs_d,
    input  logic                     in_rt_v,
    input  logic [W_RX_A-1:0]        in_rt_a,
    input  logic [W_RX_D-1:0]        in_rt_d,
    input  logic [W_IMM_D-1:0]       in_imm_d,
    input  logic [W_PC_D-1:0]        in_pc_d,
    input  logic [N_WB-1:0]          wb_valid,
    input  logic [N_WB*W_RX_A-1:0]   wb_a,
    input  logic [N_WB*W_RX_D-1:0]   wb_d,
    output logic [N_PIP-1:0]         iss_valid,
    input  logic [N_PIP-1:0]         iss_ready,
    output logic [N_PIP*W_UOPS-1:0]  iss_uops,
    output logic [N_PIP*W_RX_A-1:0]  iss_rd_a,
    output logic [N_PIP*W_RX_D-1:0]  iss_rs_d,
    output logic [N_PIP*W_RX_D-1:0]  iss_rt_d,
    output logic [N_PIP*W_IMM_D-1:0] iss_imm_d,
    output logic [N_PIP*W_PC_D-1:0]  iss_pc_d,
    output logic [CW-1:0]            count
);

    logic [CW-1:0]      count_q, count_d;
    logic [PIPW-1:0]    pip_q  [DEPTH], pip_d  [DEPTH];
    logic [W_UOPS-1:0]  uops_q [DEPTH], uops_d [DEPTH];
    logic [W_RX_A-1:0]  rd_q   [DEPTH], rd_d   [DEPTH];
    logic               rs_v_q [DEPTH], rs_v_d [DEPTH];
    logic [W_RX_A-1:0]  rs_a_q [DEPTH], rs_a_d [DEPTH];
    logic [W_RX_D-1:0]  rs_d_q [DEPTH], rs_d_d [DEPTH];
    logic               rt_v_q [DEPTH], rt_v_d [DEPTH];
    logic [W_RX_A-1:0]  rt_a_q [DEPTH], rt_a_d [DEPTH];
    logic [W_RX_D-1:0]  rt_d_q [DEPTH], rt_d_d [DEPTH];
    logic [W_IMM_D-1:0] imm_q  [DEPTH], imm_d  [DEPTH];
    logic [W_PC_D-1:0]  pc_q   [DEPTH], pc_d   [DEPTH];

    logic               wk_rs_v_s [DEPTH];
    logic [W_RX_D-1:0]  wk_rs_d_s [DEPTH];
    logic               wk_rt_v_s [DEPTH];
    logic [W_RX_D-1:0]  wk_rt_d_s [DEPTH];

    logic               ins_rs_v_s, ins_rt_v_s;
    logic [W_RX_D-1:0]  ins_rs_d_s, ins_rt_d_s;

    logic [DEPTH-1:0]   rdy_s;
    logic [DEPTH-1:0]   match_s [N_PIP];
    logic [IW-1:0]      sel_s   [N_PIP];
    logic [N_PIP-1:0]   fire_s;
    logic [DEPTH-1:0]   rm_s;
    logic [CW-1:0]      n_iss_s;
    logic [CW-1:0]      ins_slot_s;
    logic               ins_s;
    logic [IW-1:0]      dst_s;
    int                 shift_s;

    for (genvar i = 0; i < DEPTH; i++) begin : g_wake
        resv_entry_wake #(.N_WB(N_WB), .W_RX_A(W_RX_A), .W_RX_D(W_RX_D)) u_wake (
            .rs_v_i     (rs_v_q[i]),
            .rs_a_i     (rs_a_q[i]),
            .rs_d_i     (rs_d_q[i]),
            .rt_v_i     (rt_v_q[i]),
            .rt_a_i     (rt_a_q[i]),
            .rt_d_i     (rt_d_q[i]),
            .wb_valid_i (wb_valid),
            .wb_a_i     (wb_a),
            .wb_d_i     (wb_d),
            .rs_v_o     (wk_rs_v_s[i]),
            .rs_d_o     (wk_rs_d_s[i]),
            .rt_v_o     (wk_rt_v_s[i]),
            .rt_d_o     (wk_rt_d_s[i])
        );
    end

`ifdef RS_WB_BYPASS_EN
    resv_entry_wake #(.N_WB(N_WB), .W_RX_A(W_RX_A), .W_RX_D(W_RX_D)) u_ins_wake (
        .rs_v_i     (in_rs_v),
        .rs_a_i     (in_rs_a),
        .rs_d_i     (in_rs_d),
        .rt_v_i     (in_rt_v),
        .rt_a_i     (in_rt_a),
        .rt_d_i     (in_rt_d),
        .wb_valid_i (wb_valid),
        .wb_a_i     (wb_a),
        .wb_d_i     (wb_d),
        .rs_v_o     (ins_rs_v_s),
        .rs_d_o     (ins_rs_d_s),
        .rt_v_o     (ins_rt_v_s),
        .rt_d_o     (ins_rt_d_s)
    );
`else
    assign ins_rs_v_s = in_rs_v;
    assign ins_rs_d_s = in_rs_d;
    assign ins_rt_v_s = in_rt_v;
    assign ins_rt_d_s = in_rt_d;
`endif

    // Readiness uses registered operand flags only, so a wakeup becomes issuable one cycle later.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy_s[i] = (CW'(i) < count_q) && rs_v_q[i] && rt_v_q[i];
        end
        for (int p = 0; p < N_PIP; p++) begin
            sel_s[p] = {IW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                match_s[p][i] = rdy_s[i] && (pip_q[i] == PIPW'(p));
            end
            iss_valid[p] = |match_s[p];
            for (int i = DEPTH - 1; i >= 0; i--) begin
                sel_s[p] = match_s[p][i] ? IW'(i) : sel_s[p];
            end
        end
    end

    // Handshakes, removal mask and the slot a new uop lands in after this edge's collapse.
    always_comb begin
        n_iss_s = {CW{1'b0}};
        rm_s    = {DEPTH{1'b0}};
        for (int p = 0; p < N_PIP; p++) begin
            fire_s[p] = iss_valid[p] & iss_ready[p];
            n_iss_s   = n_iss_s + CW'(fire_s[p]);
            for (int i = 0; i < DEPTH; i++) begin
                rm_s[i] = rm_s[i] | (fire_s[p] & (sel_s[p] == IW'(i)));
            end
        end
        ins_s      = in_valid & in_ready & ~flush;
        ins_slot_s = count_q - n_iss_s;
    end

    // Collapse survivors toward slot 0 with their wakeups merged, then append the dispatched uop.
    always_comb begin
        pip_d   = pip_q;
        uops_d  = uops_q;
        rd_d    = rd_q;
        rs_v_d  = rs_v_q;
        rs_a_d  = rs_a_q;
        rs_d_d  = rs_d_q;
        rt_v_d  = rt_v_q;
        rt_a_d  = rt_a_q;
        rt_d_d  = rt_d_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        shift_s = 0;
        dst_s   = {IW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && !rm_s[i]) begin
                dst_s         = IW'(i - shift_s);
                pip_d[dst_s]  = pip_q[i];
                uops_d[dst_s] = uops_q[i];
                rd_d[dst_s]   = rd_q[i];
                rs_v_d[dst_s] = wk_rs_v_s[i];
                rs_a_d[dst_s] = rs_a_q[i];
                rs_d_d[dst_s] = wk_rs_d_s[i];
                rt_v_d[dst_s] = wk_rt_v_s[i];
                rt_a_d[dst_s] = rt_a_q[i];
                rt_d_d[dst_s] = wk_rt_d_s[i];
                imm_d[dst_s]  = imm_q[i];
                pc_d[dst_s]   = pc_q[i];
            end else begin
                shift_s = shift_s + 1;
            end
        end
        if (flush) begin
            count_d = {CW{1'b0}};
        end else if (ins_s) begin
            count_d                  = count_q - n_iss_s + CW'(1'b1);
            pip_d[IW'(ins_slot_s)]   = in_pip;
            uops_d[IW'(ins_slot_s)]  = in_uops;
            rd_d[IW'(ins_slot_s)]    = in_rd_a;
            rs_v_d[IW'(ins_slot_s)]  = ins_rs_v_s;
            rs_a_d[IW'(ins_slot_s)]  = in_rs_a;
            rs_d_d[IW'(ins_slot_s)]  = ins_rs_d_s;
            rt_v_d[IW'(ins_slot_s)]  = ins_rt_v_s;
            rt_a_d[IW'(ins_slot_s)]  = in_rt_a;
            rt_d_d[IW'(ins_slot_s)]  = ins_rt_d_s;
            imm_d[IW'(ins_slot_s)]   = in_imm_d;
            pc_d[IW'(ins_slot_s)]    = in_pc_d;
        end else begin
            count_d = count_q - n_iss_s;
        end
    end

    // Entry array and occupancy; clear_n empties the station without waiting for a clock.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count_q <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                pip_q[i]  <= {PIPW{1'b0}};
                uops_q[i] <= {W_UOPS{1'b0}};
                rd_q[i]   <= {W_RX_A{1'b0}};
                rs_v_q[i] <= 1'b0;
                rs_a_q[i] <= {W_RX_A{1'b0}};
                rs_d_q[i] <= {W_RX_D{1'b0}};
                rt_v_q[i] <= 1'b0;
                rt_a_q[i] <= {W_RX_A{1'b0}};
                rt_d_q[i] <= {W_RX_D{1'b0}};
                imm_q[i]  <= {W_IMM_D{1'b0}};
                pc_q[i]   <= {W_PC_D{1'b0}};
            end
        end else begin
            count_q <= count_d;
            pip_q   <= pip_d;
            uops_q  <= uops_d;
            rd_q    <= rd_d;
            rs_v_q  <= rs_v_d;
            rs_a_q  <= rs_a_d;
            rs_d_q  <= rs_d_d;
            rt_v_q  <= rt_v_d;
            rt_a_q  <= rt_a_d;
            rt_d_q  <= rt_d_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
        end
    end

    // Issue payload per pipe, forced to zero when the pipe has nothing ready.
    always_comb begin
        for (int p = 0; p < N_PIP; p++) begin
            iss_uops[p*W_UOPS +: W_UOPS]    = iss_valid[p] ? uops_q[sel_s[p]] : W_UOPS'(UNUSED_OP);
            iss_rd_a[p*W_RX_A +: W_RX_A]    = iss_valid[p] ? rd_q[sel_s[p]]   : {W_RX_A{1'b0}};
            iss_rs_d[p*W_RX_D +: W_RX_D]    = iss_valid[p] ? rs_d_q[sel_s[p]] : {W_RX_D{1'b0}};
            iss_rt_d[p*W_RX_D +: W_RX_D]    = iss_valid[p] ? rt_d_q[sel_s[p]] : {W_RX_D{1'b0}};
            iss_imm_d[p*W_IMM_D +: W_IMM_D] = iss_valid[p] ? imm_q[sel_s[p]]  : {W_IMM_D{1'b0}};
            iss_pc_d[p*W_PC_D +: W_PC_D]    = iss_valid[p] ? pc_q[sel_s[p]]   : {W_PC_D{1'b0}};
        end
    end

    assign in_ready = (count_q < CW'(DEPTH));
    assign count    = count_q;

endmodule

// File: tb/tb_resv_station_pipn.sv
// Directed bench for resv_station_pipn: fill, age order, dual issue, wakeup priority, flush, reset.
module tb_resv_station_pipn;

    logic        clk = 1'b0;
    logic        clear_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [0:0]  in_pip;
    logic [5:0]  in_uops;
    logic [4:0]  in_rd_a;
    logic        in_rs_v;
    logic [4:0]  in_rs_a;
    logic [31:0] in_rs_d;
    logic        in_rt_v;
    logic [4:0]  in_rt_a;
    logic [31:0] in_rt_d;
    logic [31:0] in_imm_d;
    logic [31:0] in_pc_d;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_a;
    logic [63:0] wb_d;
    logic [1:0]  iss_valid;
    logic [1:0]  iss_ready;
    logic [11:0] iss_uops;
    logic [9:0]  iss_rd_a;
    logic [63:0] iss_rs_d;
    logic [63:0] iss_rt_d;
    logic [63:0] iss_imm_d;
    logic [63:0] iss_pc_d;
    logic [3:0]  count;

    int n_vec = 0;
    int n_err = 0;

    resv_station_pipn dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pip    (in_pip),
        .in_uops   (in_uops),
        .in_rd_a   (in_rd_a),
        .in_rs_v   (in_rs_v),
        .in_rs_a   (in_rs_a),
        .in_rs_d   (in_rs_d),
        .in_rt_v   (in_rt_v),
        .in_rt_a   (in_rt_a),
        .in_rt_d   (in_rt_d),
        .in_imm_d  (in_imm_d),
        .in_pc_d   (in_pc_d),
        .wb_valid  (wb_valid),
        .wb_a      (wb_a),
        .wb_d      (wb_d),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_uops  (iss_uops),
        .iss_rd_a  (iss_rd_a),
        .iss_rs_d  (iss_rs_d),
        .iss_rt_d  (iss_rt_d),
        .iss_imm_d (iss_imm_d),
        .iss_pc_d  (iss_pc_d),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        wb_valid  = 2'b00;
        iss_ready = 2'b00;
        flush     = 1'b0;
    endtask

    // Dispatch one uop; payload fields are derived from the uop number.
    task automatic put(input int pip, input int uop, input logic rs_v, input logic [4:0] rs_a,
                       input logic [31:0] rs_d, input logic rt_v);
        in_valid = 1'b1;
        in_pip   = 1'(pip);
        in_uops  = 6'(uop);
        in_rd_a  = 5'(uop);
        in_rs_v  = rs_v;
        in_rs_a  = rs_a;
        in_rs_d  = rs_d;
        in_rt_v  = rt_v;
        in_rt_a  = 5'd30;
        in_rt_d  = 32'h200 + 32'(uop);
        in_imm_d = 32'h100 + 32'(uop);
        in_pc_d  = 32'h1000 + 32'(uop * 4);
    endtask

    task automatic wbset(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
        wb_valid = v;
        wb_a     = {a1, a0};
        wb_d     = {d1, d0};
    endtask

    initial begin
        int pips [8] = '{0, 0, 1, 1, 0, 1, 0, 1};
        clear_n = 1'b0;
        idle();
        put(0, 0, 1'b0, 5'd0, 32'd0, 1'b0);
        in_valid = 1'b0;
        wbset(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        #3;
        chk("rst_count", count, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_iss", iss_valid, 0);
        #9;
        clear_n = 1'b1;
        tick();

        // Fill eight waiting uops; slot 5 waits on r3, others on r16+slot.
        for (int i = 0; i < 8; i++) begin
            put(pips[i], i + 1, 1'b0, (i == 5) ? 5'd3 : 5'(16 + i), 32'd0, 1'b1);
            tick();
            if (i == 3) chk("fill_half", count, 4);
        end
        chk("fill_count", count, 8);
        chk("fill_ready", in_ready, 0);
        chk("fill_iss", iss_valid, 0);
        put(0, 9, 1'b1, 5'd0, 32'd0, 1'b1);
        tick();
        idle();
        chk("held_count", count, 8);

        wbset(2'b01, 5'd3, 32'hDEAD0005, 5'd0, 32'd0);
        #1;
        chk("same_cyc_iss", iss_valid, 0);
        tick();
        idle();
        chk("wake_iss", iss_valid, 2'b10);
        chk("wake_uop1", iss_uops[11:6], 6);
        chk("wake_rs1", iss_rs_d[63:32], 32'hDEAD0005);
        chk("wake_rt1", iss_rt_d[63:32], 32'h206);
        chk("wake_pc1", iss_pc_d[63:32], 32'h1018);
        chk("wake_imm1", iss_imm_d[63:32], 32'h106);
        chk("wake_rd1", iss_rd_a[9:5], 6);
        chk("idle_uop0", iss_uops[5:0], 0);

        // Age order: slots 1 and 4 ready on pipe 0.
        wbset(2'b11, 5'd17, 32'd1, 5'd20, 32'd2);
        tick();
        idle();
        chk("age_iss", iss_valid, 2'b11);
        chk("age_first", iss_uops[5:0], 2);
        iss_ready = 2'b01;
        tick();
        idle();
        chk("age_count", count, 7);
        chk("age_second", iss_uops[5:0], 5);
        chk("age_rs0", iss_rs_d[31:0], 2);
        chk("age_pipe1", iss_uops[11:6], 6);

        // Dual issue, then dual issue with insert at count 5.
        iss_ready = 2'b11;
        tick();
        idle();
        chk("dual_count", count, 5);
        chk("dual_iss", iss_valid, 0);
        wbset(2'b11, 5'd16, 32'h11, 5'd19, 32'h44);
        tick();
        idle();
        chk("dual_uop0", iss_uops[5:0], 1);
        chk("dual_uop1", iss_uops[11:6], 4);
        iss_ready = 2'b11;
        put(0, 32, 1'b1, 5'd0, 32'h77, 1'b1);
        tick();
        idle();
        chk("dins_count", count, 4);
        chk("dins_iss", iss_valid, 2'b01);
        chk("dins_uop0", iss_uops[5:0], 32);
        chk("dins_rs0", iss_rs_d[31:0], 32'h77);
        wbset(2'b01, 5'd22, 32'h70, 5'd0, 32'd0);
        tick();
        idle();
        chk("dins_older", iss_uops[5:0], 7);

        // Register 0 is never woken; channel 0 wins a clash.
        put(1, 33, 1'b0, 5'd0, 32'd0, 1'b1);
        wbset(2'b11, 5'd0, 32'h55, 5'd0, 32'h66);
        tick();
        idle();
        chk("zero_count", count, 5);
        wbset(2'b11, 5'd0, 32'h55, 5'd0, 32'h66);
        tick();
        idle();
        chk("zero_iss", iss_valid, 2'b01);
        wbset(2'b11, 5'd18, 32'hA, 5'd18, 32'hB);
        tick();
        idle();
        chk("clash_iss", iss_valid, 2'b11);
        chk("clash_uop1", iss_uops[11:6], 3);
        chk("clash_rs1", iss_rs_d[63:32], 32'hA);
        iss_ready = 2'b11;
        tick();
        idle();
        chk("clash_count", count, 3);
        chk("clash_after", iss_valid, 2'b01);
        chk("clash_uop0", iss_uops[5:0], 32);

        // Flush beats a same-cycle insert.
        flush = 1'b1;
        put(0, 34, 1'b1, 5'd0, 32'd0, 1'b1);
        tick();
        idle();
        chk("flush_count", count, 0);
        chk("flush_iss", iss_valid, 0);
        chk("flush_ready", in_ready, 1);
        chk("flush_pc", iss_pc_d, 0);

        put(0, 35, 1'b0, 5'd9, 32'd0, 1'b1);
        wbset(2'b01, 5'd9, 32'h99, 5'd0, 32'd0);
        tick();
        idle();
`ifdef RS_WB_BYPASS_EN
        chk("byp_iss", iss_valid, 2'b01);
        chk("byp_rs0", iss_rs_d[31:0], 32'h99);
`else
        chk("nobyp_iss", iss_valid, 2'b00);
        wbset(2'b01, 5'd9, 32'h99, 5'd0, 32'd0);
        tick();
        idle();
        chk("nobyp_wake", iss_valid, 2'b01);
        chk("nobyp_rs0", iss_rs_d[31:0], 32'h99);
`endif

        // Asynchronous reset in the middle of traffic.
        put(1, 36, 1'b1, 5'd0, 32'h5, 1'b1);
        tick();
        chk("pre_rst_iss", iss_valid, 2'b11);
        clear_n = 1'b0;
        #2;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_iss", iss_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_uops", iss_uops, 0);
        idle();
        #2;
        clear_n = 1'b1;
        tick();
        chk("post_rst_count", count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
